dpd_lut_gain_apply: RTL

//  DPD actuator gain stage, directly downstream of the magnitude/LUT-address stage.

---
 rtl/dpd_pkg.sv | 35 +++
 rtl/cmult_round_sat.sv | 67 ++++++
 rtl/dpd_lut_gain_apply.sv | 117 +++++++++++
 3 files changed

// File: rtl/dpd_pkg.sv
// Shared DPD types and helpers: packed {I, Q} samples,
// 16-bit saturation and pack/unpack.
package dpd_pkg;

    localparam int DPD_IQ_W = 16;
    localparam int GAIN_ONE = 16384;

    typedef logic signed [DPD_IQ_W-1:0] iq_comp_t;

    typedef struct packed {
        iq_comp_t i;
        iq_comp_t q;
    } iq_t;

    function automatic iq_comp_t sat16(input logic signed [32:0] v);
        if (v > 33'sd32767) begin
            return 16'sh7fff;
        end else if (v < -33'sd32768) begin
            return 16'sh8000;
        end
        return v[15:0];
    endfunction

    function automatic iq_t iq_pack(input iq_comp_t ci, input iq_comp_t cq);
        iq_t r;
        r.i = ci;
        r.q = cq;
        return r;
    endfunction

    function automatic iq_t iq_unpack(input logic [31:0] w);
        return iq_t'(w);
    endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// Two-stage complex multiply: registered partial products,
// then combine, round half-up, saturate and register.
module cmult_round_sat
    import dpd_pkg::*;
#(
    parameter int GAIN_FRAC = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  iq_t  t,
    input  iq_t  g,
    output iq_t  y,
    output logic y_valid
);

    localparam logic signed [32:0] RND = 33'sd1 <<< (GAIN_FRAC - 1);

    logic signed [31:0] p_ii;
    logic signed [31:0] p_qq;
    logic signed [31:0] p_iq;
    logic signed [31:0] p_qi;
    logic               m1_valid;

    logic signed [32:0] sum_i;
    logic signed [32:0] sum_q;
    logic signed [32:0] rnd_i;
    logic signed [32:0] rnd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_ii     <= '0;
            p_qq     <= '0;
            p_iq     <= '0;
            p_qi     <= '0;
            m1_valid <= 1'b0;
        end else begin
            m1_valid <= in_valid;
            if (in_valid) begin
                p_ii <= 32'(t.i) * 32'(g.i);
                p_qq <= 32'(t.q) * 32'(g.q);
                p_iq <= 32'(t.i) * 32'(g.q);
                p_qi <= 32'(t.q) * 32'(g.i);
            end
        end
    end

    always_comb begin
        sum_i = 33'(p_ii) - 33'(p_qq);
        sum_q = 33'(p_iq) + 33'(p_qi);
        rnd_i = (sum_i + RND) >>> GAIN_FRAC;
        rnd_q = (sum_q + RND) >>> GAIN_FRAC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= m1_valid;
            if (m1_valid) begin
                y <= iq_pack(sat16(rnd_i), sat16(rnd_q));
            end
        end
    end

endmodule

// File: rtl/dpd_lut_gain_apply.sv
// DPD actuator gain stage: aligns tu with its LUT address, applies a
// complex gain from a ping-pong LUT and emits the rounded, saturated tx.
module dpd_lut_gain_apply
    import dpd_pkg::*;
#(
    parameter int LUT_DATA_WIDTH = 32,
    parameter int LUT_ADDR_WIDTH = 10,
    parameter int MAG_LATENCY    = 16,
    parameter int GAIN_FRAC      = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LUT_DATA_WIDTH-1:0] tu,
    input  logic                      tu_valid,
    input  logic [LUT_ADDR_WIDTH-1:0] mag,
    input  logic                      lut_bypass,
    input  logic                      lut_wr_en,
    input  logic [LUT_ADDR_WIDTH-1:0] lut_wr_addr,
    input  logic [LUT_DATA_WIDTH-1:0] lut_wr_data,
    input  logic                      bank_swap_req,
    output logic                      bank_swap_ack,
    output logic                      active_bank,
    output logic [LUT_DATA_WIDTH-1:0] tx,
    output logic                      tx_valid
);

    localparam int       DEPTH = 2 * (2 ** LUT_ADDR_WIDTH);
    localparam iq_comp_t BYP_I = iq_comp_t'(2 ** GAIN_FRAC);

    logic [LUT_DATA_WIDTH-1:0] dl_data [MAG_LATENCY];
    logic [MAG_LATENCY-1:0]    dl_valid;

    logic [LUT_DATA_WIDTH-1:0] lut_mem [DEPTH];
    logic [LUT_DATA_WIDTH-1:0] rd_data;

    logic [LUT_DATA_WIDTH-1:0] r_data;
    logic                      r_valid;
    logic                      r_bypass;
    iq_t                       gain;
    iq_t                       tx_iq;

    logic                      swap_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAG_LATENCY; i++) begin
                dl_data[i] <= '0;
            end
            dl_valid <= '0;
        end else begin
            dl_data[0] <= tu;
            for (int i = 1; i < MAG_LATENCY; i++) begin
                dl_data[i] <= dl_data[i-1];
            end
            dl_valid <= {dl_valid[MAG_LATENCY-2:0], tu_valid};
        end
    end

    // Writes always go to the shadow bank, so the datapath never sees them.
    always_ff @(posedge clk) begin
        if (lut_wr_en) begin
            lut_mem[{~active_bank, lut_wr_addr}] <= lut_wr_data;
        end
        rd_data <= lut_mem[{active_bank, mag}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_bypass <= 1'b0;
        end else begin
            r_data   <= dl_data[MAG_LATENCY-1];
            r_valid  <= dl_valid[MAG_LATENCY-1];
            r_bypass <= lut_bypass;
        end
    end

    always_comb begin
        gain = iq_unpack(rd_data);
        if (r_bypass) begin
            gain = iq_pack(BYP_I, iq_comp_t'(0));
        end
    end

    // A req seen while a swap is pending folds into that swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            swap_pend     <= 1'b0;
            active_bank   <= 1'b0;
            bank_swap_ack <= 1'b0;
        end else begin
            bank_swap_ack <= swap_pend;
            if (swap_pend) begin
                active_bank <= ~active_bank;
                swap_pend   <= 1'b0;
            end else begin
                swap_pend <= bank_swap_req;
            end
        end
    end

    cmult_round_sat #(
        .GAIN_FRAC (GAIN_FRAC)
    ) u_cmult (
        .clk      (clk),
        .rst      (rst),
        .in_valid (r_valid),
        .t        (iq_unpack(r_data)),
        .g        (gain),
        .y        (tx_iq),
        .y_valid  (tx_valid)
    );

    assign tx = tx_iq;

endmodule
